interrupt_controller: RTL
=========================

Name: interrupt_controller

Overview:
Initiator side of the CPU interrupt interface. It collects external interrupt request lines and resolves them by mask and fixed priority. It then drives a single held interrupt request, plus a vector, into the fetch stage's interrupt input. It tracks the acknowledge/return handshake so only one interrupt is in service at a time, with no nesting.

Parameters:
NUM_SOURCES, 4, number of external request lines (1..8)
VEC_BASE, 32'h0000_0000, PC of vector 0
VEC_STRIDE, 32'h0000_0002, PC distance between consecutive vectors
MASK_RESET, all ones, reset value of mask register (1 = enabled)

Ports:
i_clk  in  1  clock; all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_irq  in  NUM_SOURCES  external request lines, already synchronous to i_clk; rising edge = request
i_mask_we  in  1  write strobe for mask register
i_mask_data  in  NUM_SOURCES  new mask value
i_int_ack  in  1  CPU has taken the interrupt (pulse from fetch/hazard logic)
i_int_done  in  1  CPU executed return-from-interrupt (pulse)
o_interrupt  out  1  interrupt request to fetch stage, held until acknowledged
o_vector  out  3  index of the source being requested/serviced
o_vector_addr  out  32  VEC_BASE + o_vector*VEC_STRIDE
o_pending  out  NUM_SOURCES  pending register (debug/status)
o_in_service  out  1  high while the ISR is running

Behaviour:
- Reset (synchronous, active-high): state=IDLE; pending=0; edge history=0; mask=MASK_RESET; o_interrupt=0; o_vector=0; o_vector_addr=VEC_BASE; o_in_service=0. Reset mid-request or mid-service abandons the request with no ack needed.
- Edge detect: edge[k] = i_irq[k] & ~prev[k]. prev is registered every cycle. A line already high in the first cycle after reset counts as an edge.
- Pending: on edge[k], pending[k] becomes 1 next cycle. A clear from ack and a new edge on the same source in the same cycle leave pending=1, because set wins. Held-high lines do not re-trigger.
- Mask: i_mask_we loads mask next cycle. Masking never clears pending; a masked pending source fires once unmasked.
- Eligible = pending & mask. Winner = lowest index set (index 0 highest priority).
- FSM states: IDLE, REQUEST, IN_SERVICE (encoding in package).
  - IDLE: if eligible != 0, go to REQUEST. Register o_vector=winner and o_vector_addr, and set o_interrupt=1 in the same edge.
  - REQUEST: o_interrupt held 1 and o_vector frozen, regardless of later mask writes or higher-priority arrivals. On i_int_ack: clear pending[o_vector], o_interrupt=0, o_in_service=1, go to IN_SERVICE, all on the next edge.
  - IN_SERVICE: o_interrupt=0. New edges still set pending. On i_int_done: o_in_service=0, go to IDLE. The next arbitration happens in IDLE, so the minimum gap from done to the next o_interrupt is 2 cycles.
- Ignored events: i_int_ack outside REQUEST; i_int_done outside IN_SERVICE.
- Latency: irq edge at cycle t → pending at t+1 → o_interrupt at t+2 (from IDLE).
- Arithmetic: o_vector_addr computed with 32-bit unsigned wrap; o_vector zero-extended.
- o_pending reflects the register directly; all other outputs are registered.

Decomposition:
- Shared package intc_pkg: state encoding constants (IDLE=2'd0, REQUEST=2'd1, IN_SERVICE=2'd2) and vector index width (3).
- One sub-module, irq_edge_detector: per-line prev register plus edge output, with synchronous reset. Arbitration and FSM stay in the top.

Test Plan:
- Single request: i_irq[2] rises at cycle 5 → o_pending=0100 at 6, o_interrupt=1 with o_vector=2 and o_vector_addr=0x4 at 7. Ack at 9 → o_interrupt=0, o_in_service=1, pending=0 at 10. Done at 14 → o_in_service=0 at 15.
- Priority: edges on sources 3 and 1 in the same cycle → vector 1 served first. After done, source 3 requested with o_vector_addr=0x6.
- Mask: mask=1110, edge on source 0 → pending=0001, no o_interrupt. Write mask=1111 → o_interrupt 2 cycles after the write strobe, vector 0.
- Freeze and no nesting: while in REQUEST for vector 2, edge on source 0 → o_vector stays 2. During IN_SERVICE, o_interrupt stays 0. After done, vector 0 is requested.
- Ack/edge collision: edge on source 2 in the same cycle as ack of vector 2 → pending[2] stays 1 and is re-requested after done.
- Reset mid-service: i_reset during IN_SERVICE with pending=1000 → next cycle all outputs at reset values, state IDLE, no stale request. A line held high after reset triggers a request at cycle 2.

Source files
------------

// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, vector width
// and the fixed-priority picker.
package intc_pkg;

    localparam int VEC_W = 3;
    localparam int MAX_SOURCES = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQUEST    = 2'd1,
        IN_SERVICE = 2'd2
    } intc_state_e;

    // Lowest set bit wins; index 0 is the highest priority.
    function automatic logic [VEC_W-1:0] lowest_set(input logic [MAX_SOURCES-1:0] v);
        logic [VEC_W-1:0] idx;
        idx = '0;
        for (int k = MAX_SOURCES - 1; k >= 0; k--) begin
            if (v[k]) idx = VEC_W'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_edge_detector.sv
// Rising-edge detector for one request line. History clears on reset, so a
// line that is already high just after reset is seen as a fresh request.
module irq_edge_detector (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_irq,
    output logic o_edge
);

    logic prev;

    always_ff @(posedge i_clk) begin
        if (i_reset) prev <= 1'b0;
        else         prev <= i_irq;
    end

    assign o_edge = i_irq & ~prev;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt initiator: latches request edges, arbitrates by mask and fixed
// priority, and runs the request/ack/done handshake with the fetch stage.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int                     NUM_SOURCES = 4,
    parameter logic [31:0]            VEC_BASE    = 32'h0000_0000,
    parameter logic [31:0]            VEC_STRIDE  = 32'h0000_0002,
    parameter logic [NUM_SOURCES-1:0] MASK_RESET  = '1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NUM_SOURCES-1:0] i_irq,
    input  logic                   i_mask_we,
    input  logic [NUM_SOURCES-1:0] i_mask_data,
    input  logic                   i_int_ack,
    input  logic                   i_int_done,
    output logic                   o_interrupt,
    output logic [VEC_W-1:0]       o_vector,
    output logic [31:0]            o_vector_addr,
    output logic [NUM_SOURCES-1:0] o_pending,
    output logic                   o_in_service
);

    intc_state_e            state, state_nxt;
    logic [NUM_SOURCES-1:0] edges;
    logic [NUM_SOURCES-1:0] pending, pending_nxt, pend_clr;
    logic [NUM_SOURCES-1:0] mask;
    logic [NUM_SOURCES-1:0] eligible;
    logic [MAX_SOURCES-1:0] eligible_ext;
    logic [VEC_W-1:0]       winner;
    logic                   interrupt_nxt;
    logic [VEC_W-1:0]       vector_nxt;
    logic [31:0]            addr_nxt;
    logic                   in_service_nxt;

    for (genvar k = 0; k < NUM_SOURCES; k++) begin : g_edge
        irq_edge_detector u_edge (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_irq   (i_irq[k]),
            .o_edge  (edges[k])
        );
    end

    assign eligible     = pending & mask;
    assign eligible_ext = MAX_SOURCES'(eligible);
    assign winner       = lowest_set(eligible_ext);
    assign o_pending    = pending;

    always_comb begin
        state_nxt      = state;
        interrupt_nxt  = o_interrupt;
        vector_nxt     = o_vector;
        addr_nxt       = o_vector_addr;
        in_service_nxt = o_in_service;
        pend_clr       = '0;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    state_nxt     = REQUEST;
                    interrupt_nxt = 1'b1;
                    vector_nxt    = winner;
                    addr_nxt      = VEC_BASE + 32'(winner) * VEC_STRIDE;
                end
            end
            // Vector is frozen here; later arrivals or mask writes wait.
            REQUEST: begin
                if (i_int_ack) begin
                    state_nxt      = IN_SERVICE;
                    interrupt_nxt  = 1'b0;
                    in_service_nxt = 1'b1;
                    for (int k = 0; k < NUM_SOURCES; k++) begin
                        if (o_vector == VEC_W'(k)) pend_clr[k] = 1'b1;
                    end
                end
            end
            IN_SERVICE: begin
                if (i_int_done) begin
                    state_nxt      = IDLE;
                    in_service_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt      = IDLE;
                interrupt_nxt  = 1'b0;
                in_service_nxt = 1'b0;
            end
        endcase
        // A new edge beats an ack clear on the same source.
        pending_nxt = (pending & ~pend_clr) | edges;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= IDLE;
            pending       <= '0;
            mask          <= MASK_RESET;
            o_interrupt   <= 1'b0;
            o_vector      <= '0;
            o_vector_addr <= VEC_BASE;
            o_in_service  <= 1'b0;
        end else begin
            state         <= state_nxt;
            pending       <= pending_nxt;
            if (i_mask_we) mask <= i_mask_data;
            o_interrupt   <= interrupt_nxt;
            o_vector      <= vector_nxt;
            o_vector_addr <= addr_nxt;
            o_in_service  <= in_service_nxt;
        end
    end

endmodule
